// File: rtl/tape_pkg.sv
// Shared types and defaults for the cassette stream player.
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  localparam logic [7:0] THRESH_DEFAULT = 8'h80;

endpackage

// File: rtl/sync_fifo.sv
// Register-based show-ahead FIFO with flush; rdata is valid whenever not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign count = wr_ptr_q - rd_ptr_q;
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop & ~empty & ~flush;
    do_push  = push & (~full | do_pop) & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tape_stream.sv
// Cassette stream player: prefetches tape bytes from SDRAM into a FIFO and
// plays them out at a Q-tick-derived sample rate.
module tape_stream
  import tape_pkg::*;
#(
  parameter int unsigned ADDR_W     = 25,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 12,
  parameter logic [7:0]  THRESH     = THRESH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              q_en,
  input  logic              en,
  input  logic              play_toggle,
  input  logic              rewind,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic              sdram_rd,
  input  logic              sdram_ready,
  input  logic [7:0]        sdram_data,
  output logic [7:0]        sample,
  output logic              data,
  output logic              playing,
  output logic              eot,
  output logic              underrun,
  output logic [ADDR_W-1:0] position
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] pos_q, pos_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [7:0]        sample_q, sample_d;
  logic              rd_q, rd_d;
  logic              playing_q, playing_d;
  logic              eot_q, eot_d;
  logic              underrun_q, underrun_d;

  logic              fifo_push, fifo_pop, fifo_flush;
  logic              fifo_full, fifo_empty;
  logic [7:0]        fifo_rdata;
  logic [CW-1:0]     fifo_count;
  logic              run;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (fifo_push),
    .wdata (sdram_data),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pos_d      = pos_q;
    div_d      = div_q;
    sample_d   = sample_q;
    playing_d  = playing_q;
    eot_d      = eot_q;
    underrun_d = underrun_q;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    run        = en & playing_q & ~eot_q;

    // A request is only launched from IDLE, so count alone covers the in-flight slot.
    unique case (state_q)
      IDLE:  if (fifo_count < CW'(FIFO_DEPTH) && addr_q < tape_len) state_d = REQ;
      REQ:   state_d = WAIT;
      WAIT:  if (sdram_ready) begin
               state_d   = IDLE;
               fifo_push = ~fifo_full;
               if (addr_q < tape_len) addr_d = addr_q + ADDR_W'(1);
             end
      DRAIN: if (sdram_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (q_en && run) begin
      if (div_q == rate_div) begin
        div_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sample_d = fifo_rdata;
          pos_d    = pos_q + ADDR_W'(1);
        end else if (pos_q < tape_len) begin
          underrun_d = 1'b1;
        end else begin
          eot_d    = 1'b1;
          sample_d = '0;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    if (play_toggle && !eot_q) playing_d = ~playing_q;

    // Rewind overrides pop and fetch write; an outstanding read is drained and dropped.
    if (rewind) begin
      fifo_push  = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
      addr_d     = '0;
      pos_d      = '0;
      div_d      = '0;
      eot_d      = 1'b0;
      underrun_d = 1'b0;
      sample_d   = '0;
      if (state_q == IDLE || (state_q != REQ && sdram_ready)) state_d = IDLE;
      else                                                     state_d = DRAIN;
    end

    rd_d = (state_d == REQ);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      pos_q      <= '0;
      div_q      <= '0;
      sample_q   <= '0;
      rd_q       <= 1'b0;
      playing_q  <= 1'b1;
      eot_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pos_q      <= pos_d;
      div_q      <= div_d;
      sample_q   <= sample_d;
      rd_q       <= rd_d;
      playing_q  <= playing_d;
      eot_q      <= eot_d;
      underrun_q <= underrun_d;
    end
  end

  assign sdram_addr = addr_q;
  assign sdram_rd   = rd_q;
  assign sample     = sample_q;
  assign data       = (sample_q >= THRESH);
  assign playing    = playing_q;
  assign eot        = eot_q;
  assign underrun   = underrun_q;
  assign position   = pos_q;

endmodule

// File: tb/tb_tape_stream.sv
// Directed bench for tape_stream with a behavioural SDRAM responder.
module tb_tape_stream;

  logic        clk = 1'b0;
  logic        reset, q_en, en, play_toggle, rewind;
  logic [11:0] rate_div;
  logic [24:0] tape_len, sdram_addr, position;
  logic        sdram_rd, sdram_ready;
  logic [7:0]  sdram_data, sample;
  logic        data, playing, eot, underrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [32];
  int lat = 1;
  int pend = 0;
  int paddr = 0;
  int cyc = 0;
  int rd_count = 0;
  int rd_log [32];
  int rd_cyc [32];

  always #5 clk = ~clk;

  tape_stream #(
    .ADDR_W     (25),
    .FIFO_DEPTH (8),
    .DIV_W      (12),
    .THRESH     (8'h80)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .q_en        (q_en),
    .en          (en),
    .play_toggle (play_toggle),
    .rewind      (rewind),
    .rate_div    (rate_div),
    .tape_len    (tape_len),
    .sdram_addr  (sdram_addr),
    .sdram_rd    (sdram_rd),
    .sdram_ready (sdram_ready),
    .sdram_data  (sdram_data),
    .sample      (sample),
    .data        (data),
    .playing     (playing),
    .eot         (eot),
    .underrun    (underrun),
    .position    (position)
  );

  // SDRAM responder: answers each read 'lat' cycles later with a one-cycle ready.
  initial begin
    sdram_ready = 1'b0;
    sdram_data  = 8'h00;
    forever begin
      @(negedge clk);
      cyc++;
      sdram_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          sdram_ready = 1'b1;
          sdram_data  = mem[paddr % 32];
        end
      end
      if (sdram_rd && rd_count < 32) begin
        pend             = lat;
        paddr            = int'(sdram_addr);
        rd_log[rd_count] = int'(sdram_addr);
        rd_cyc[rd_count] = cyc;
        rd_count++;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic qpulse(input int n);
    for (int i = 0; i < n; i++) begin
      q_en = 1'b1;
      step();
      q_en = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    q_en = 1'b0; play_toggle = 1'b0; rewind = 1'b0;
    pend = 0; rd_count = 0;
    step(); step();
    reset = 1'b1;
  endtask

  task automatic toggle_play();
    play_toggle = 1'b1;
    step();
    play_toggle = 1'b0;
  endtask

  task automatic wait_reads(input int n, input int budget);
    int t;
    t = 0;
    while (rd_count < n && t < budget) begin
      step();
      t++;
    end
    check("wait_reads", rd_count, n);
  endtask

  initial begin
    int guard;
    logic eot_early;
    reset = 1'b0; q_en = 1'b0; en = 1'b0; play_toggle = 1'b0; rewind = 1'b0;
    rate_div = '0; tape_len = 25'd20;

    // Reset state
    step();
    check("rst_playing", playing, 1);
    check("rst_sample", sample, 8'h00);
    check("rst_data", data, 0);
    check("rst_rd", sdram_rd, 0);
    check("rst_addr", sdram_addr, 0);
    check("rst_pos", position, 0);
    check("rst_eot", eot, 0);
    check("rst_underrun", underrun, 0);

    // Prefetch: exactly FIFO_DEPTH reads with motor off
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'h40 + i);
    lat = 2; tape_len = 25'd20; en = 1'b0;
    do_reset();
    repeat (60) step();
    check("pf_reads", rd_count, 8);
    for (int i = 0; i < 8; i++) check("pf_addr", rd_log[i], i);
    check("pf_sdram_addr", sdram_addr, 8);
    check("pf_sample", sample, 8'h00);
    check("pf_pos", position, 0);

    // Playout 00,FF,7F,80 with rate_div=2, fill spacing 3 cycles at 1-cycle ready
    mem[0] = 8'h00; mem[1] = 8'hFF; mem[2] = 8'h7F; mem[3] = 8'h80;
    lat = 1; tape_len = 25'd4; rate_div = 12'd2;
    do_reset();
    repeat (20) step();
    check("po_reads", rd_count, 4);
    check("po_spacing01", rd_cyc[1] - rd_cyc[0], 3);
    check("po_spacing12", rd_cyc[2] - rd_cyc[1], 3);
    en = 1'b1;
    qpulse(2);
    check("po_pos_q2", position, 0);
    qpulse(1);
    check("po_s0", sample, 8'h00); check("po_d0", data, 0); check("po_p1", position, 1);
    qpulse(3);
    check("po_s1", sample, 8'hFF); check("po_d1", data, 1); check("po_p2", position, 2);
    qpulse(3);
    check("po_s2", sample, 8'h7F); check("po_d2", data, 0); check("po_p3", position, 3);
    qpulse(3);
    check("po_s3", sample, 8'h80); check("po_d3", data, 1); check("po_p4", position, 4);
    check("po_eot_pre", eot, 0);
    qpulse(3);
    check("po_eot", eot, 1);
    check("po_eot_sample", sample, 8'h00);
    toggle_play();
    check("po_toggle_ignored", playing, 1);

    // Pause and relay freeze the divider mid-count
    for (int i = 0; i < 8; i++) mem[i] = 8'(8'h10 * (i + 1));
    lat = 1; tape_len = 25'd8; rate_div = 12'd3; en = 1'b1;
    do_reset();
    repeat (40) step();
    qpulse(2);
    toggle_play();
    check("pa_paused", playing, 0);
    qpulse(5);
    check("pa_pos_frozen", position, 0);
    check("pa_sample_frozen", sample, 8'h00);
    toggle_play();
    check("pa_resumed", playing, 1);
    qpulse(1);
    check("pa_pos_mid", position, 0);
    qpulse(1);
    check("pa_pos_bound", position, 1);
    check("pa_sample_bound", sample, 8'h10);
    qpulse(1);
    en = 1'b0;
    qpulse(6);
    en = 1'b1;
    qpulse(2);
    check("en_pos_frozen", position, 1);
    qpulse(1);
    check("en_pos_bound", position, 2);
    check("en_sample_bound", sample, 8'h20);

    // Asynchronous reset mid-stream
    toggle_play();
    check("ar_paused", playing, 0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    check("ar_playing", playing, 1);
    check("ar_sample", sample, 8'h00);
    check("ar_data", data, 0);
    check("ar_pos", position, 0);
    check("ar_addr", sdram_addr, 0);
    check("ar_rd", sdram_rd, 0);
    pend = 0; rd_count = 0;
    tape_len = 25'd0; rate_div = 12'd0;
    step(); step();
    reset = 1'b1;
    repeat (5) step();
    qpulse(1);
    check("nt_eot", eot, 1);
    check("nt_sample", sample, 8'h00);
    check("nt_no_reads", rd_count, 0);

    // Rewind while a read is outstanding
    for (int i = 0; i < 32; i++) mem[i] = 8'(8'hA0 + i);
    lat = 3; tape_len = 25'd8; en = 1'b0; rate_div = 12'd0;
    do_reset();
    wait_reads(4, 60);
    rewind = 1'b1;
    step();
    rewind = 1'b0;
    check("rw_addr", sdram_addr, 0);
    check("rw_pos", position, 0);
    check("rw_sample", sample, 8'h00);
    wait_reads(5, 30);
    check("rw_first_addr", rd_log[4], 0);
    repeat (60) step();
    check("rw_total_reads", rd_count, 12);
    check("rw_addr_end", sdram_addr, 8);
    en = 1'b1;
    qpulse(1);
    check("rw_first_sample", sample, 8'hA0);
    check("rw_pos1", position, 1);

    // Underrun with slow SDRAM and a boundary on every cycle
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    lat = 10; tape_len = 25'd4; rate_div = 12'd0; en = 1'b1;
    do_reset();
    q_en = 1'b1;
    step();
    check("ur_flag", underrun, 1);
    check("ur_sample_held", sample, 8'h00);
    check("ur_eot", eot, 0);
    guard = 0; eot_early = 1'b0;
    while (position != 25'd1 && guard < 100) begin
      step(); guard++;
      if (eot) eot_early = 1'b1;
    end
    check("ur_pos1", position, 1);
    check("ur_s0", sample, 8'h11);
    step(); guard++;
    check("ur_hold_sample", sample, 8'h11);
    check("ur_hold_pos", position, 1);
    while (position != 25'd4 && guard < 200) begin
      step(); guard++;
      if (eot) eot_early = 1'b1;
    end
    check("ur_pos4", position, 4);
    check("ur_s3", sample, 8'h44);
    check("ur_eot_early", eot_early, 0);
    check("ur_eot_at_len", eot, 0);
    step();
    q_en = 1'b0;
    check("ur_eot_final", eot, 1);
    check("ur_eot_sample", sample, 8'h00);
    check("ur_sticky", underrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tape_stream.md
# tape_stream

Parametrised cassette/stream player. It replaces the fixed single-bit cassette reader: it prefetches tape image bytes from SDRAM into a small FIFO and plays them out at a programmable rate, timed by the CPU Q enable. Outputs are an 8-bit sample, the comparator bit fed to the PIA cassette input, and status flags for the OSD. It sits between the `sdram` instance and `po8`, and is gated by the motor relay (`cas_relay`) and the OSD Play/Pause and Rewind triggers.

## Interface
Parameters:
- `ADDR_W`, 25: SDRAM byte address width.
- `FIFO_DEPTH`, 8: prefetch depth; power of two, ≥2.
- `DIV_W`, 12: width of the rate divider.
- `THRESH`, 8'h80: comparator threshold for `data`.

Ports:
- `clk` in 1: system clock (57.272 MHz).
- `reset` in 1: asynchronous, active-low.
- `q_en` in 1: one-cycle CPU Q tick.
- `en` in 1: motor relay; when low, playback freezes.
- `play_toggle` in 1: one-cycle pulse; toggles play/pause.
- `rewind` in 1: one-cycle pulse; returns to address 0.
- `rate_div` in DIV_W: Q ticks per sample, minus 1.
- `tape_len` in ADDR_W: image length in bytes; 0 means no tape.
- `sdram_addr` out ADDR_W: read address.
- `sdram_rd` out 1: read request.
- `sdram_ready` in 1: one-cycle acknowledge; `sdram_data` is valid in the same cycle.
- `sdram_data` in 8: read data.
- `sample` out 8: current sample.
- `data` out 1: `sample >= THRESH`.
- `playing` out 1: play latch.
- `eot` out 1: end of tape reached.
- `underrun` out 1: sticky; FIFO was empty at a sample boundary.
- `position` out ADDR_W: number of samples consumed.

## Operation
- **Reset values:**
  - `playing` = 1 (auto-play, matching current behaviour).
  - `sample` = 8'h00, `data` = 0.
  - `sdram_rd` = 0, `sdram_addr` = 0, `position` = 0.
  - `eot` = 0, `underrun` = 0.
  - FIFO empty, divider 0, fetch FSM in IDLE.
- **Fetch FSM (IDLE, REQ, WAIT):**
  - IDLE → REQ when FIFO has a free slot (including one reserved for the in-flight word) and `sdram_addr < tape_len`.
  - REQ asserts `sdram_rd` for exactly one cycle, then → WAIT.
  - WAIT → IDLE on `sdram_ready`: write `sdram_data` to the FIFO and increment `sdram_addr`.
  - Fetching runs regardless of `en` and `playing`, so the FIFO is full before the motor starts.
- **Playout:**
  - Runs only when `run = en & playing & ~eot`.
  - On each `q_en` with `run`: if the divider equals `rate_div`, clear the divider and perform a sample boundary; otherwise increment the divider.
- **Sample boundary:**
  - FIFO non-empty: pop into `sample` and increment `position`.
  - FIFO empty with `position < tape_len`: hold `sample` and set `underrun`.
  - FIFO empty with `position == tape_len`: set `eot`, then drive `sample` = 8'h00.
- **Play toggle:** `play_toggle` flips `playing`. It is ignored while `eot` is set; `rewind` clears `eot`.
- **Rewind:**
  - Next cycle: flush the FIFO, clear `sdram_addr`, `position`, divider, `eot` and `underrun`; `sample` becomes 8'h00.
  - `playing` is left unchanged.
  - Rewind during WAIT: the FSM moves to a DRAIN state, discards the returning word, then goes to IDLE.
- **Simultaneous events:**
  - `rewind` beats a pop and a fetch write in the same cycle.
  - A FIFO push and pop in the same cycle are both performed; the count is unchanged.
- **`tape_len` = 0:** no fetches; the first sample boundary sets `eot`.
- **Widths:** FIFO pointers are log2(FIFO_DEPTH)+1 bits, wrapping naturally. `sdram_addr` saturates at `tape_len`; no wrap.

## Timing
- `sdram_rd` is a single-cycle pulse, registered.
- At most one request is outstanding. There is no timeout; WAIT holds until `sdram_ready`.
- Fill latency from reset with a 1-cycle `sdram_ready` response: a new request every 3 cycles. That is REQ(1) + WAIT(1 minimum) + IDLE(1).
- `sample` updates the cycle after a boundary `q_en`. `data` is combinational from the registered `sample`.
- `eot` and `underrun` are registered, asserting the same cycle as the `sample` update.
- `en` low freezes the divider mid-count; counting resumes on the next `q_en` with `en` high.

## Structure
- Shared package `tape_pkg`:
  - fetch FSM enum `{IDLE, REQ, WAIT, DRAIN}`.
  - default `THRESH`.
- Sub-module `sync_fifo #(WIDTH=8, DEPTH)`: push, pop, flush, full, empty, count. Register-based, no read latency (show-ahead).
- Top-level integration:
  - `sdram.rd` ← `sdram_rd`; `sdram.ready` ← `sdram_ready`.
  - `data` → `casdout`.
  - `q_en` from `clk_Q_out` edge detect.

## Test plan
- **Prefetch:** reset, `tape_len`=20, `en`=0, ready after 2 cycles → exactly `FIFO_DEPTH` (8) reads issued, addresses 0..7; `sample` stays 00.
- **Playout:** image bytes 00,FF,7F,80, `rate_div`=2, `en`=1 → `sample` steps every 3rd `q_en`; `data` sequence 0,1,0,1; `position` reaches 4; then `eot`=1 and `sample`=00.
- **Pause and relay:** `play_toggle` mid-divider → `sample`, `position` and divider frozen; toggle again → next boundary after the remaining ticks. `en`=0 behaves the same.
- **Rewind mid-WAIT:** `rewind` during an outstanding read → late data discarded; next request at address 0; `position`=0; first popped sample = byte 0.
- **Underrun:** `rate_div`=0, `q_en` every cycle, ready delayed 10 cycles → `underrun`=1 and `sample` held; `eot` stays 0 until `position`==`tape_len`.
- **Asynchronous reset mid-stream:** assert `reset` low → all outputs at reset values immediately; `tape_len`=0 → `eot` at the first boundary with no SDRAM reads.
